// File: rtl/imem_pkg.sv
// Shared types and default sizes for the programmable instruction memory.
package imem_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DEPTH  = 256;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_LOAD  = 2'd1,
        ST_READY = 2'd2
    } imem_state_e;

    // Index width for a storage array; a single-entry array still needs one bit.
    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/instr_mem_prog_if.sv
// Program-load and fetch bus for instr_mem_prog.
// parity_err exists only when IMEM_PARITY_EN is defined.
interface instr_mem_prog_if
    import imem_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) ();

    logic              prog_start;
    logic              prog_valid;
    logic [DATA_W-1:0] prog_data;
    logic              prog_last;
    logic              prog_ready;
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_stall;
    logic              fetch_valid;
    logic [DATA_W-1:0] fetch_data;
    logic              fetch_oob;
    logic [ADDR_W:0]   loaded_count;
    logic              prog_overflow;
`ifdef IMEM_PARITY_EN
    logic              parity_err;
`endif

    modport master (
        output prog_start, prog_valid, prog_data, prog_last,
        output fetch_req, fetch_addr, fetch_stall,
        input  prog_ready, fetch_valid, fetch_data, fetch_oob,
`ifdef IMEM_PARITY_EN
        input  parity_err,
`endif
        input  loaded_count, prog_overflow
    );

    modport slave (
        input  prog_start, prog_valid, prog_data, prog_last,
        input  fetch_req, fetch_addr, fetch_stall,
        output prog_ready, fetch_valid, fetch_data, fetch_oob,
`ifdef IMEM_PARITY_EN
        output parity_err,
`endif
        output loaded_count, prog_overflow
    );

endinterface

// File: rtl/imem_array.sv
// Instruction storage: one synchronous write port, one registered read port.
// Contents are deliberately never reset.
module imem_array
    import imem_pkg::*;
#(
    parameter int WIDTH  = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    localparam int IDX_W = idx_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr[IDX_W-1:0]] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr[IDX_W-1:0]];
        end
    end

endmodule

// File: rtl/instr_mem_prog.sv
// Instruction memory loaded through a streaming program port and read by a 1-cycle fetch port.
// Define IMEM_PARITY_EN to store an even-parity bit per word and report parity_err on fetch.
module instr_mem_prog
    import imem_pkg::*;
#(
    parameter int                DATA_W   = DEF_DATA_W,
    parameter int                ADDR_W   = DEF_ADDR_W,
    parameter int                DEPTH    = DEF_DEPTH,
    parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
    input logic              clk,
    input logic              reset,
    instr_mem_prog_if.slave  bus
);

`ifdef IMEM_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);

    imem_state_e       state_q;
    imem_state_e       state_d;
    logic [ADDR_W-1:0] wr_ptr_q;
    logic [ADDR_W:0]   count_q;
    logic              ovf_q;
    logic              fetch_valid_q;
    logic              oob_q;
    logic              nop_q;

    logic              prog_ready;
    logic              accept;
    logic              at_last_addr;
    logic              fetch_go;
    logic              fetch_oob_d;
    logic              wr_en;
    logic              rd_en;
    logic [MEM_W-1:0]  wr_word;
    logic [MEM_W-1:0]  rd_word;

    // A word arriving alongside prog_start is dropped: the restart wins.
    assign prog_ready   = (state_q == ST_LOAD);
    assign accept       = bus.prog_valid && prog_ready && !bus.prog_start;
    assign at_last_addr = (wr_ptr_q == LAST_ADDR);
    assign wr_en        = accept && !reset;

    assign fetch_oob_d  = ({1'b0, bus.fetch_addr} >= count_q);
    assign fetch_go     = (state_q == ST_READY) && bus.fetch_req && !bus.fetch_stall
                          && !bus.prog_start && !reset;
    assign rd_en        = fetch_go && !fetch_oob_d;

`ifdef IMEM_PARITY_EN
    assign wr_word = {^bus.prog_data, bus.prog_data};
`else
    assign wr_word = bus.prog_data;
`endif

    imem_array #(
        .WIDTH  (MEM_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr_q),
        .wr_data (wr_word),
        .rd_en   (rd_en),
        .rd_addr (bus.fetch_addr),
        .rd_data (rd_word)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // A load ends on prog_last or when the final address is written.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (bus.prog_start) state_d = ST_LOAD;
            ST_LOAD: begin
                if (bus.prog_start) begin
                    state_d = ST_LOAD;
                end else if (accept && (bus.prog_last || at_last_addr)) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: if (bus.prog_start) state_d = ST_LOAD;
            default:  state_d = ST_EMPTY;
        endcase
    end

    // nop_q selects NOP_WORD so out-of-range fetches and reset never expose stale array data.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q      <= '0;
            count_q       <= '0;
            ovf_q         <= 1'b0;
            fetch_valid_q <= 1'b0;
            oob_q         <= 1'b0;
            nop_q         <= 1'b1;
        end else begin
            if (bus.prog_start) begin
                wr_ptr_q <= '0;
                count_q  <= '0;
                ovf_q    <= 1'b0;
            end else if (accept) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
                count_q  <= count_q + CNT_ONE;
                if (at_last_addr && !bus.prog_last) begin
                    ovf_q <= 1'b1;
                end
            end

            if (bus.prog_start) begin
                fetch_valid_q <= 1'b0;
            end else if (!bus.fetch_stall) begin
                fetch_valid_q <= fetch_go;
                if (fetch_go) begin
                    oob_q <= fetch_oob_d;
                    nop_q <= fetch_oob_d;
                end
            end
        end
    end

    assign bus.prog_ready    = prog_ready;
    assign bus.fetch_valid   = fetch_valid_q;
    assign bus.fetch_data    = nop_q ? NOP_WORD : rd_word[DATA_W-1:0];
    assign bus.fetch_oob     = oob_q;
    assign bus.loaded_count  = count_q;
    assign bus.prog_overflow = ovf_q;
`ifdef IMEM_PARITY_EN
    assign bus.parity_err    = fetch_valid_q && !nop_q && (^rd_word);
`endif

endmodule

// File: tb/tb_instr_mem_prog.sv
// Scoreboard bench for instr_mem_prog: a DEPTH=256 instance checked by a fetch monitor and a DEPTH=4 instance for overflow.
// The parity test runs only when IMEM_PARITY_EN is defined.
module tb_instr_mem_prog;
    import imem_pkg::*;

    localparam int           DW  = 16;
    localparam int           AW  = 8;
    localparam int           DPA = 256;
    localparam int           DPB = 4;
    localparam logic [DW-1:0] NOP = '0;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    instr_mem_prog_if #(.DATA_W(DW), .ADDR_W(AW)) bus_a ();
    instr_mem_prog_if #(.DATA_W(DW), .ADDR_W(AW)) bus_b ();

    instr_mem_prog #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DPA), .NOP_WORD(NOP)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    instr_mem_prog #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DPB), .NOP_WORD(NOP)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    int vec_count = 0;
    int err_count = 0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_count++;
        if (obs !== exp) begin
            err_count++;
            $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Behavioural model of dut_a: program state, contents and pending fetch results.
    int               m_state = 0;
    int               m_count = 0;
    logic [DW-1:0]    m_mem [DPA];
    logic [DW:0]      exp_q [$];
    logic             rst_seen   = 1'b1;
    logic             start_seen = 1'b0;
    logic             stall_seen = 1'b0;

    always @(posedge clk) begin
        rst_seen   = reset;
        start_seen = bus_a.prog_start;
        stall_seen = bus_a.fetch_stall;
        if (reset) begin
            m_state = 0;
            m_count = 0;
            exp_q.delete();
        end else begin
            if (m_state == 2 && bus_a.fetch_req && !bus_a.fetch_stall && !bus_a.prog_start) begin
                if (int'(bus_a.fetch_addr) >= m_count) begin
                    exp_q.push_back({1'b1, NOP});
                end else begin
                    exp_q.push_back({1'b0, m_mem[bus_a.fetch_addr]});
                end
            end
            if (bus_a.prog_start) begin
                m_state = 1;
                m_count = 0;
            end else if (m_state == 1 && bus_a.prog_valid) begin
                m_mem[m_count] = bus_a.prog_data;
                m_count++;
                if (bus_a.prog_last || m_count == DPA) begin
                    m_state = 2;
                end
            end
        end
    end

    logic          held_v = 1'b0;
    logic [DW-1:0] held_d = NOP;
    logic          held_o = 1'b0;
    logic [DW:0]   exp_e;

    always @(negedge clk) begin
        if (rst_seen) begin
            held_v = 1'b0;
            held_d = NOP;
            held_o = 1'b0;
            checkOutput("rst_valid", 32'(bus_a.fetch_valid), 32'(0));
            checkOutput("rst_data",  32'(bus_a.fetch_data),  32'(NOP));
            checkOutput("rst_oob",   32'(bus_a.fetch_oob),   32'(0));
        end else if (start_seen) begin
            held_v = 1'b0;
            checkOutput("start_clears_valid", 32'(bus_a.fetch_valid), 32'(0));
        end else if (stall_seen) begin
            checkOutput("stall_valid", 32'(bus_a.fetch_valid), 32'(held_v));
            checkOutput("stall_data",  32'(bus_a.fetch_data),  32'(held_d));
            checkOutput("stall_oob",   32'(bus_a.fetch_oob),   32'(held_o));
        end else if (exp_q.size() > 0) begin
            exp_e  = exp_q.pop_front();
            held_v = 1'b1;
            held_d = exp_e[DW-1:0];
            held_o = exp_e[DW];
            checkOutput("fetch_valid", 32'(bus_a.fetch_valid), 32'(1));
            checkOutput("fetch_data",  32'(bus_a.fetch_data),  32'(held_d));
            checkOutput("fetch_oob",   32'(bus_a.fetch_oob),   32'(held_o));
        end else begin
            held_v = 1'b0;
            checkOutput("idle_valid", 32'(bus_a.fetch_valid), 32'(0));
            checkOutput("idle_data",  32'(bus_a.fetch_data),  32'(held_d));
        end
    end

    task automatic applyStimulus(input logic start, input logic valid, input logic [DW-1:0] data,
                                 input logic last, input logic req, input logic [AW-1:0] addr,
                                 input logic stall);
        bus_a.prog_start  = start;
        bus_a.prog_valid  = valid;
        bus_a.prog_data   = data;
        bus_a.prog_last   = last;
        bus_a.fetch_req   = req;
        bus_a.fetch_addr  = addr;
        bus_a.fetch_stall = stall;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic applyStimulusB(input logic start, input logic valid, input logic [DW-1:0] data,
                                  input logic last, input logic req, input logic [AW-1:0] addr);
        bus_b.prog_start  = start;
        bus_b.prog_valid  = valid;
        bus_b.prog_data   = data;
        bus_b.prog_last   = last;
        bus_b.fetch_req   = req;
        bus_b.fetch_addr  = addr;
        bus_b.fetch_stall = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        bus_a.prog_start = 0; bus_a.prog_valid = 0; bus_a.prog_data = '0; bus_a.prog_last = 0;
        bus_a.fetch_req  = 0; bus_a.fetch_addr = '0; bus_a.fetch_stall = 0;
        bus_b.prog_start = 0; bus_b.prog_valid = 0; bus_b.prog_data = '0; bus_b.prog_last = 0;
        bus_b.fetch_req  = 0; bus_b.fetch_addr = '0; bus_b.fetch_stall = 0;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_ready",    32'(bus_a.prog_ready),    32'(0));
        checkOutput("rst_count",    32'(bus_a.loaded_count),  32'(0));
        checkOutput("rst_overflow", 32'(bus_a.prog_overflow), 32'(0));
        reset = 1'b0;

        // Fetch while EMPTY is ignored
        applyStimulus(0, 0, '0, 0, 1, 8'd0, 0);

        // Three-word load, with a fetch attempted mid-load
        applyStimulus(1, 0, '0, 0, 0, 8'd0, 0);
        checkOutput("load_ready", 32'(bus_a.prog_ready), 32'(1));
        applyStimulus(0, 1, 16'h1111, 0, 1, 8'd0, 0);
        applyStimulus(0, 1, 16'h2222, 0, 0, 8'd0, 0);
        applyStimulus(0, 1, 16'h3333, 1, 0, 8'd0, 0);
        checkOutput("load3_count",    32'(bus_a.loaded_count),  32'(3));
        checkOutput("load3_ready",    32'(bus_a.prog_ready),    32'(0));
        checkOutput("load3_overflow", 32'(bus_a.prog_overflow), 32'(0));

        // In-range, out-of-range and boundary fetches
        applyStimulus(0, 0, '0, 0, 1, 8'd1, 0);
        applyStimulus(0, 0, '0, 0, 0, 8'd0, 0);
        applyStimulus(0, 0, '0, 0, 1, 8'd5, 0);
        applyStimulus(0, 0, '0, 0, 1, 8'd3, 0);
        applyStimulus(0, 0, '0, 0, 1, 8'd2, 0);
        applyStimulus(0, 0, '0, 0, 1, 8'd255, 0);
        applyStimulus(0, 0, '0, 0, 0, 8'd0, 0);

        // Stall holds addr-0 data while addr 2 is requested
        applyStimulus(0, 0, '0, 0, 1, 8'd0, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, '0, 0, 1, 8'd2, 1);
        end
        applyStimulus(0, 0, '0, 0, 1, 8'd2, 0);
        applyStimulus(0, 0, '0, 0, 0, 8'd0, 0);

        // Restart after two words of a longer load; the word beside prog_start is dropped
        applyStimulus(1, 0, '0, 0, 0, 8'd0, 0);
        applyStimulus(0, 1, 16'hAAA0, 0, 0, 8'd0, 0);
        applyStimulus(0, 1, 16'hAAA1, 0, 0, 8'd0, 0);
        applyStimulus(1, 1, 16'hDEAD, 0, 0, 8'd0, 0);
        checkOutput("restart_count", 32'(bus_a.loaded_count), 32'(0));
        applyStimulus(0, 1, 16'hBBB0, 0, 0, 8'd0, 0);
        applyStimulus(0, 1, 16'hBBB1, 1, 0, 8'd0, 0);
        checkOutput("restart_final_count", 32'(bus_a.loaded_count), 32'(2));
        applyStimulus(0, 0, '0, 0, 1, 8'd0, 0);
        applyStimulus(0, 0, '0, 0, 1, 8'd1, 0);
        applyStimulus(0, 0, '0, 0, 1, 8'd2, 0);

        // prog_start clears fetch_valid even while stalled
        applyStimulus(0, 0, '0, 0, 1, 8'd0, 0);
        applyStimulus(1, 0, '0, 0, 0, 8'd0, 1);
        applyStimulus(0, 1, 16'h4444, 1, 0, 8'd0, 0);
        checkOutput("reload_count", 32'(bus_a.loaded_count), 32'(1));
        applyStimulus(0, 0, '0, 0, 1, 8'd0, 0);

`ifdef IMEM_PARITY_EN
        checkOutput("parity_clean", 32'(bus_a.parity_err), 32'(0));
        dut_a.u_array.mem[0] = dut_a.u_array.mem[0] ^ ((DW + 1)'(1) << DW);
        applyStimulus(0, 0, '0, 0, 1, 8'd0, 0);
        checkOutput("parity_err",       32'(bus_a.parity_err),  32'(1));
        checkOutput("parity_err_valid", 32'(bus_a.fetch_valid), 32'(1));
`endif

        // Reset from READY returns to EMPTY behaviour
        reset = 1'b1;
        applyStimulus(0, 1, 16'h5555, 0, 1, 8'd0, 0);
        reset = 1'b0;
        checkOutput("rst2_count", 32'(bus_a.loaded_count), 32'(0));
        applyStimulus(0, 0, '0, 0, 1, 8'd0, 0);
        applyStimulus(0, 0, '0, 0, 0, 8'd0, 0);

        // DEPTH=4 instance: a load without prog_last overflows
        applyStimulusB(1, 0, '0, 0, 0, 8'd0);
        checkOutput("b_ready_load", 32'(bus_b.prog_ready), 32'(1));
        for (int i = 0; i < DPB; i++) begin
            applyStimulusB(0, 1, 16'hA0A0 + 16'(i), 0, 0, 8'd0);
        end
        checkOutput("b_overflow", 32'(bus_b.prog_overflow), 32'(1));
        checkOutput("b_count",    32'(bus_b.loaded_count),  32'(4));
        checkOutput("b_ready",    32'(bus_b.prog_ready),    32'(0));
        applyStimulusB(0, 1, 16'hBEEF, 0, 0, 8'd0);
        checkOutput("b_count_hold", 32'(bus_b.loaded_count), 32'(4));
        applyStimulusB(0, 0, '0, 0, 1, 8'd3);
        checkOutput("b_fetch_valid", 32'(bus_b.fetch_valid), 32'(1));
        checkOutput("b_fetch_data",  32'(bus_b.fetch_data),  32'(16'hA0A3));
        checkOutput("b_fetch_oob",   32'(bus_b.fetch_oob),   32'(0));
        applyStimulusB(0, 0, '0, 0, 1, 8'd4);
        checkOutput("b_oob_data", 32'(bus_b.fetch_data), 32'(NOP));
        checkOutput("b_oob_flag", 32'(bus_b.fetch_oob),  32'(1));
        applyStimulusB(1, 0, '0, 0, 0, 8'd0);
        checkOutput("b_ovf_clear",   32'(bus_b.prog_overflow), 32'(0));
        checkOutput("b_count_clear", 32'(bus_b.loaded_count),  32'(0));
        checkOutput("b_valid_clear", 32'(bus_b.fetch_valid),   32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
        $finish;
    end

endmodule

// File: doc/instr_mem_prog.md
INSTR_MEM_PROG -- requirements
Module: instr_mem_prog

Interface
REQ-001 Parameter DATA_W, default 16: instruction word width in bits.
REQ-002 Parameter ADDR_W, default 8: fetch/program address width.
REQ-003 Parameter DEPTH, default 256: number of words; SHALL satisfy DEPTH <= 2**ADDR_W.
REQ-004 Parameter NOP_WORD, default all-zero DATA_W value: word returned for unloaded or out-of-range fetches.
REQ-005 Port clk  in  1: the single clock; all state changes on its rising edge.
REQ-006 Port reset  in  1: synchronous, active-high reset.
REQ-007 Port prog_start  in  1: single-cycle pulse that begins a program load at address 0.
REQ-008 Port prog_valid  in  1: prog_data/prog_last valid this cycle.
REQ-009 Port prog_data  in  DATA_W: instruction word to store.
REQ-010 Port prog_last  in  1: the current word is the final word of the program.
REQ-011 Port prog_ready  out  1: the block accepts a program word this cycle.
REQ-012 Port fetch_req  in  1: fetch request at fetch_addr.
REQ-013 Port fetch_addr  in  ADDR_W: fetch address.
REQ-014 Port fetch_stall  in  1: hold the current fetch output.
REQ-015 Port fetch_valid  out  1: fetch_data is valid.
REQ-016 Port fetch_data  out  DATA_W: fetched instruction.
REQ-017 Port fetch_oob  out  1: the presented fetch targeted an address >= loaded_count.
REQ-018 Port loaded_count  out  ADDR_W+1: number of words in the current program.
REQ-019 Port prog_overflow  out  1: sticky flag; the load hit DEPTH without prog_last.

Function
REQ-020 The FSM SHALL have three states: EMPTY, LOAD, READY.
REQ-021 EMPTY->LOAD on prog_start; READY->LOAD on prog_start; LOAD->READY on an accepted word with prog_last, or on an accepted word at address DEPTH-1.
REQ-022 prog_ready SHALL be 1 only in LOAD; a word is accepted when prog_valid and prog_ready are both 1.
REQ-023 On entry to LOAD, the write pointer and loaded_count SHALL clear to 0 and prog_overflow SHALL clear; each accepted word writes at the pointer, then the pointer and loaded_count increment by 1.
REQ-024 An accepted word at address DEPTH-1 without prog_last SHALL set prog_overflow and end the load with loaded_count = DEPTH.
REQ-025 prog_start during LOAD SHALL restart the load at address 0; a word presented in the same cycle SHALL be ignored.
REQ-026 Fetches SHALL be serviced only in READY; fetch_req in EMPTY or LOAD SHALL produce no fetch_valid.
REQ-027 Fetch latency SHALL be 1 cycle: a fetch_req in READY at cycle N drives fetch_valid=1 with the registered fetch_data at N+1.
REQ-028 For fetch_addr >= loaded_count, fetch_data SHALL be NOP_WORD and fetch_oob SHALL be 1; otherwise fetch_oob SHALL be 0.
REQ-029 While fetch_stall=1, fetch_valid, fetch_data and fetch_oob SHALL hold their values and new fetch_req SHALL be ignored.
REQ-030 When fetch_stall=0 and fetch_req=0, fetch_valid SHALL drop to 0 on the next cycle and fetch_data SHALL hold its value.
REQ-031 On the transition into LOAD, fetch_valid SHALL clear on the following cycle.

Reset
REQ-032 Reset SHALL force EMPTY, with prog_ready=0, fetch_valid=0, fetch_data=NOP_WORD, fetch_oob=0, loaded_count=0 and prog_overflow=0; reset SHALL take priority over all other inputs.
REQ-033 Memory contents SHALL NOT be cleared by reset; after reset the block SHALL behave as if empty.

Configuration
REQ-034 With IMEM_PARITY_EN defined, each stored word SHALL carry an even-parity bit, and an output parity_err SHALL assert together with fetch_valid when the stored parity mismatches; without the macro, the parity bit, the check and the port SHALL be absent.

Structure
REQ-035 Package imem_pkg SHALL hold the FSM state enum and the default parameter constants.
REQ-036 Sub-module imem_array SHALL hold the storage: one synchronous write port and one registered read port.

Verification
REQ-037 Reset, load 3 words 0x1111/0x2222/0x3333 with last on the third -> READY, loaded_count=3; fetch addr 1 -> fetch_data=0x2222 and fetch_valid=1 one cycle later.
REQ-038 Fetch addr 5 with loaded_count=3 -> fetch_data=0x0000 and fetch_oob=1.
REQ-039 Fetch addr 0, then fetch_stall=1 for 3 cycles while fetch_req is applied to addr 2 -> output holds addr-0 data; after the stall is released, addr-2 data appears 1 cycle later.
REQ-040 With DEPTH=4, stream 4 words without last -> prog_overflow=1, loaded_count=4, state READY.
REQ-041 prog_start after the 2nd word of a 5-word load, then load 2 words with last -> loaded_count=2 and the new words appear at addresses 0 and 1.
REQ-042 With IMEM_PARITY_EN, force a corrupted parity bit at addr 0 and fetch it -> parity_err=1 coincident with fetch_valid.
